x_top_uart_bridge: RTL and testbench

X_TOP_UART_BRIDGE -- requirements
Module: x_top_uart_bridge

---
 rtl/x_top_uart_pkg.sv | 16 +
 rtl/x_top_uart_bridge.sv | 152 +++++++++++++++
 tb/tb_x_top_uart_bridge.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/x_top_uart_pkg.sv
// Shared types and byte constants for the UART-to-bus bridge.
package x_top_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;

endpackage

// File: rtl/x_top_uart_bridge.sv
// UART byte-frame to 32-bit bus bridge: 'W' addr data -> 'K',
// 'R' addr -> rdata, with an inter-byte timeout on partial frames.
module x_top_uart_bridge
  import x_top_uart_pkg::*;
#(
  parameter int p_timeout = 1200000
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_accept,
  output logic        o_bus_valid,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata
);

  localparam int TW = $clog2(p_timeout);
  localparam logic [TW-1:0] TMO_LAST = TW'(p_timeout - 1);

  state_t      state;
  state_t      state_nx;
  logic        op_we;
  logic [1:0]  cnt;
  logic [TW-1:0] tmo;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] resp;
  logic        bus_valid;
  logic        tx_valid;
  logic [7:0]  tx_data;

  logic cmd_hit;
  logic rx_frame;
  logic rx_take;
  logic tmo_hit;
  logic bus_done;
  logic tx_xfer;
  logic tx_last;

  assign cmd_hit  = i_rx_valid &
                    ((i_rx_data == CMD_WR) |
                     (i_rx_data == CMD_RD));
  assign rx_frame = (state == ST_ADDR) |
                    (state == ST_DATA);
  assign rx_take  = rx_frame & i_rx_valid;
  // An arriving byte outranks the expiring counter.
  assign tmo_hit  = rx_frame & ~i_rx_valid &
                    (tmo == TMO_LAST);
  assign bus_done = bus_valid & i_bus_ready;
  assign tx_xfer  = tx_valid & i_tx_accept;
  assign tx_last  = op_we | (cnt == 2'd3);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (cmd_hit) state_nx = ST_ADDR;
      ST_ADDR:
        if (rx_take && cnt == 2'd3)
          state_nx = op_we ? ST_DATA : ST_BUS;
        else if (tmo_hit)
          state_nx = ST_IDLE;
      ST_DATA:
        if (rx_take && cnt == 2'd3)
          state_nx = ST_BUS;
        else if (tmo_hit)
          state_nx = ST_IDLE;
      ST_BUS:
        if (bus_done) state_nx = ST_RESP;
      ST_RESP:
        if (tx_xfer && tx_last) state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      op_we     <= 1'b0;
      cnt       <= 2'd0;
      tmo       <= '0;
      addr      <= '0;
      wdata     <= '0;
      resp      <= '0;
      bus_valid <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      tmo <= (rx_frame && !i_rx_valid && !tmo_hit) ?
             tmo + 1'b1 : '0;
      case (state)
        ST_IDLE:
          if (cmd_hit) begin
            op_we <= (i_rx_data == CMD_WR);
            cnt   <= 2'd0;
          end
        ST_ADDR, ST_DATA:
          if (i_rx_valid) begin
            cnt <= cnt + 2'd1;
            if (state == ST_ADDR)
              addr  <= {i_rx_data, addr[31:8]};
            else
              wdata <= {i_rx_data, wdata[31:8]};
          end else if (tmo_hit) begin
            cnt <= 2'd0;
          end
        ST_BUS:
          if (!bus_valid) begin
            bus_valid <= 1'b1;
          end else if (i_bus_ready) begin
            bus_valid <= 1'b0;
            if (!op_we) resp <= i_bus_rdata;
          end
        ST_RESP:
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= op_we ? RSP_ACK : resp[7:0];
            resp     <= resp >> 8;
          end else if (i_tx_accept) begin
            if (tx_last) begin
              tx_valid <= 1'b0;
              cnt      <= 2'd0;
            end else begin
              tx_data <= resp[7:0];
              resp    <= resp >> 8;
              cnt     <= cnt + 2'd1;
            end
          end
        default: ;
      endcase
    end
  end

  assign o_bus_valid = bus_valid;
  assign o_bus_we    = op_we;
  assign o_bus_addr  = addr;
  assign o_bus_wdata = wdata;
  assign o_tx_valid  = tx_valid;
  assign o_tx_data   = tx_data;

endmodule

// File: tb/tb_x_top_uart_bridge.sv
// Bench for x_top_uart_bridge: frame-level model with expected
// bus/tx queues, plus literal pins on the reference transactions.
module tb_x_top_uart_bridge;

  localparam int TMO = 100;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_accept;
  logic        o_bus_valid;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  x_top_uart_bridge #(.p_timeout(TMO)) dut (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_rx_valid  (i_rx_valid),
    .i_rx_data   (i_rx_data),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .i_tx_accept (i_tx_accept),
    .o_bus_valid (o_bus_valid),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_ready (i_bus_ready),
    .i_bus_rdata (i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  bus_t        e;
  int          n_pass = 0;
  int          n_total = 0;
  int          bus_seen = 0;
  int          bus_lat = 0;
  int          wait_cnt = 0;
  logic [31:0] rd_val = 32'h0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic        last_we = 1'b0;
  logic [7:0]  rd_lit [4] = '{8'h78, 8'h56, 8'h34, 8'h12};

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h",
                  name, act, exp);
  endtask

  // Compare process: every bus completion and tx transfer
  logic        pv_bv = 0, pv_br = 0, pv_tv = 0, pv_ta = 0;
  logic        pv_we = 0;
  logic [31:0] pv_addr = 0, pv_wdata = 0;
  logic [7:0]  pv_td = 0;

  always @(negedge i_clk) begin
    if (!i_nrst) begin
      pv_bv = 0; pv_br = 0; pv_tv = 0; pv_ta = 0;
    end else begin
      if (o_bus_valid && pv_bv && !pv_br) begin
        chk("bus_addr_stable", o_bus_addr, pv_addr);
        chk("bus_wdata_stable", o_bus_wdata, pv_wdata);
        chk("bus_we_stable", o_bus_we, pv_we);
      end
      if (o_bus_valid && i_bus_ready) begin
        bus_seen++;
        last_addr = o_bus_addr;
        last_wdata = o_bus_wdata;
        last_we = o_bus_we;
        if (exp_bus.size() == 0) begin
          chk("bus_unexpected", 1, 0);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_we", o_bus_we, e.we);
          chk("bus_addr", o_bus_addr, e.addr);
          if (e.we) chk("bus_wdata", o_bus_wdata, e.data);
        end
      end
      if (o_tx_valid && pv_tv && !pv_ta)
        chk("tx_stable", o_tx_data, pv_td);
      if (o_tx_valid && i_tx_accept) begin
        tx_log.push_back(o_tx_data);
        if (exp_tx.size() == 0)
          chk("tx_unexpected", 1, 0);
        else
          chk("tx_byte", o_tx_data, exp_tx.pop_front());
      end
      pv_bv = o_bus_valid; pv_br = i_bus_ready;
      pv_addr = o_bus_addr; pv_wdata = o_bus_wdata;
      pv_we = o_bus_we;
      pv_tv = o_tx_valid; pv_ta = i_tx_accept;
      pv_td = o_tx_data;
    end
  end

  // Bus responder: ready after bus_lat wait cycles; rdata
  // carries junk except in the completing cycle.
  initial begin
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'hBAD0BAD0;
    forever begin
      @(posedge i_clk); #1;
      if (i_bus_ready || !o_bus_valid) begin
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'hBAD0BAD0;
        wait_cnt = 0;
      end else if (wait_cnt >= bus_lat) begin
        i_bus_ready = 1'b1;
        i_bus_rdata = rd_val;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic rx(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_valid = 1'b1;
    i_rx_data = b;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_write(input logic [31:0] a,
                            input logic [31:0] d);
    exp_bus.push_back('{we: 1'b1, addr: a, data: d});
    exp_tx.push_back(8'h4B);
    rx(8'h57);
    for (int i = 0; i < 4; i++) rx(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) rx(d[8*i +: 8]);
  endtask

  task automatic expect_read(input logic [31:0] a,
                             input logic [31:0] d);
    rd_val = d;
    exp_bus.push_back('{we: 1'b0, addr: a, data: 32'h0});
    for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a,
                           input logic [31:0] d);
    expect_read(a, d);
    rx(8'h52);
    for (int i = 0; i < 4; i++) rx(a[8*i +: 8]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_bus.size() + exp_tx.size()) != 0 && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    chk(name, exp_bus.size() + exp_tx.size(), 0);
    exp_bus.delete();
    exp_tx.delete();
    repeat (3) @(negedge i_clk);
    chk({name, "_idle"}, {o_bus_valid, o_tx_valid}, 0);
  endtask

  initial begin
    int b0;
    int n;
    i_nrst = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data = 8'h0;
    i_tx_accept = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_bus_valid", o_bus_valid, 0);
    chk("rst_bus_we", o_bus_we, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_bus_addr", o_bus_addr, 0);
    chk("rst_bus_wdata", o_bus_wdata, 0);
    @(posedge i_clk); #1;
    i_nrst = 1'b1;

    // Reference write
    bus_lat = 2;
    tx_log.delete();
    send_write(32'h40000010, 32'hDEADBEEF);
    drain("wr_ref");
    chk("lit_wr_addr", last_addr, 32'h40000010);
    chk("lit_wr_data", last_wdata, 32'hDEADBEEF);
    chk("lit_wr_we", last_we, 1);
    chk("lit_ack_n", tx_log.size(), 1);
    if (tx_log.size() >= 1) chk("lit_ack", tx_log[0], 8'h4B);

    // Reference read, ready after 5 cycles
    bus_lat = 5;
    tx_log.delete();
    send_read(32'h40000004, 32'h12345678);
    drain("rd_ref");
    chk("lit_rd_addr", last_addr, 32'h40000004);
    chk("lit_rd_we", last_we, 0);
    chk("lit_rd_n", tx_log.size(), 4);
    for (int i = 0; i < 4 && i < tx_log.size(); i++)
      chk("lit_rd_byte", tx_log[i], rd_lit[i]);

    // Extreme patterns, zero-latency bus
    bus_lat = 0;
    send_write(32'hFFFFFFFF, 32'h00000001);
    drain("wr_ones");
    send_read(32'h00000000, 32'hA5C30FF0);
    drain("rd_zero");

    // Backpressure, with an rx byte dropped during RESP
    bus_lat = 1;
    tx_log.delete();
    @(posedge i_clk); #1;
    i_tx_accept = 1'b0;
    send_read(32'h40000004, 32'h12345678);
    n = 0;
    while (!o_tx_valid && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("bp_valid_seen", o_tx_valid, 1);
    rx(8'h52);
    repeat (20) begin
      @(negedge i_clk);
      chk("bp_hold", {o_tx_valid, o_tx_data}, {1'b1, 8'h78});
    end
    @(posedge i_clk); #1;
    i_tx_accept = 1'b1;
    drain("bp");
    chk("bp_n", tx_log.size(), 4);
    for (int i = 0; i < 4 && i < tx_log.size(); i++)
      chk("bp_byte", tx_log[i], rd_lit[i]);

    // 'W' injected while the bus request is pending
    bus_lat = 10;
    send_write(32'h00000080, 32'hCAFEF00D);
    n = 0;
    while (!o_bus_valid && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("drop_bus_seen", o_bus_valid, 1);
    rx(8'h57);
    drain("drop");
    bus_lat = 1;
    send_read(32'h11223344, 32'h55667788);
    drain("post_drop");

    // Garbage, then a partial frame left to time out
    b0 = bus_seen;
    rx(8'hAA);
    rx(8'h52);
    rx(8'h01);
    rx(8'h02);
    repeat (TMO + 20) @(posedge i_clk);
    chk("tmo_no_bus", bus_seen, b0);
    chk("tmo_no_tx", o_tx_valid, 0);
    send_read(32'h40000008, 32'h0BADF00D);
    drain("post_tmo");

    // Byte lands in the very cycle the counter expires
    expect_read(32'h4000000C, 32'h00C0FFEE);
    rx(8'h52);
    repeat (TMO - 2) @(posedge i_clk);
    rx(8'h0C);
    rx(8'h00);
    rx(8'h00);
    rx(8'h40);
    drain("tmo_edge");

    // Reset after the third data byte of a write
    rx(8'h57);
    rx(8'h10); rx(8'h00); rx(8'h00); rx(8'h40);
    rx(8'hEF); rx(8'hBE); rx(8'hAD);
    @(posedge i_clk); #1;
    i_nrst = 1'b0;
    @(negedge i_clk);
    chk("rmid_ctl", {o_tx_valid, o_bus_valid, o_bus_we}, 0);
    chk("rmid_addr", o_bus_addr, 0);
    chk("rmid_wdata", o_bus_wdata, 0);
    chk("rmid_tx_data", o_tx_data, 0);
    @(posedge i_clk); #1;
    i_nrst = 1'b1;
    b0 = bus_seen;
    rx(8'hDE);
    repeat (40) @(posedge i_clk);
    chk("rmid_no_bus", bus_seen, b0);
    chk("rmid_no_tx", o_tx_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, %0d/%0d",
             n_pass, n_total);
    $fatal(1);
  end

endmodule
